// File: rtl/fetch_stall_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stall_stage_if
// Instruction-memory handshake between the fetch stage and instruction memory.
// Only one request is ever outstanding at a time.
//   req   : fetch request; held high until the response strobe arrives
//   addr  : fetch address
//   valid : one-cycle response strobe
//   data  : returned instruction, valid with 'valid'
// master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface fetch_stall_stage_if #(
  parameter int addrWidth = 32
);
  logic                 req;
  logic [addrWidth-1:0] addr;
  logic                 valid;
  logic [31:0]          data;

  modport master (output req, output addr, input valid, input data);
  modport slave  (input req, input addr, output valid, output data);
endinterface

// File: rtl/fetch_stall_stage.sv
// ---------------------------------------------------------------------------
// fetch_stall_stage
// PC register and IF/ID pipeline register of the 5-stage core. Honours the
// hazard unit's pcWrite/ifidWrite, takes EX-stage branch redirects, drives a
// single-outstanding instruction-memory request and parks a returned
// instruction in a hold buffer while the pipeline is stalled. A saturating
// counter records stall cycles for performance monitoring.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   pcWrite, ifidWrite   : hazard unit; 0 holds PC / IF/ID
//   selectMux            : hazard unit; 0 requests an ID/EX control bubble
//   branchTaken/Target   : EX-stage redirect (target bits [1:0] ignored)
//   imem                 : instruction-memory handshake (master side)
//   pc                   : current fetch PC (also drives imem.addr)
//   ifidPc/Instr/Valid   : IF/ID register contents
//   idexBubble           : registered ID/EX bubble request
//   stallCount           : saturating stall-cycle count
// ---------------------------------------------------------------------------
module fetch_stall_stage #(
  parameter int                   addrWidth = 32,
  parameter logic [addrWidth-1:0] resetPc   = 32'h0000_0000,
  parameter int                   cntWidth  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pcWrite,
  input  logic                   ifidWrite,
  input  logic                   selectMux,
  input  logic                   branchTaken,
  input  logic [addrWidth-1:0]   branchTarget,
  fetch_stall_stage_if.master    imem,
  output logic [addrWidth-1:0]   pc,
  output logic [addrWidth-1:0]   ifidPc,
  output logic [31:0]            ifidInstr,
  output logic                   ifidValid,
  output logic                   idexBubble,
  output logic [cntWidth-1:0]    stallCount
);

  localparam logic [31:0] nopInstr = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } stateT;

  stateT                state;
  logic [addrWidth-1:0] holdPc;
  logic [31:0]          holdInstr;

  logic                 stall;
  logic [addrWidth-1:0] pcPlus4;
  logic [addrWidth-1:0] alignedTarget;

  assign stall         = ~pcWrite | ~ifidWrite;
  assign pcPlus4       = pc + addrWidth'(32'd4);
  assign alignedTarget = branchTarget & ~(addrWidth'(32'd3));
  assign imem.addr     = pc;

  // Fetch FSM with PC, IF/ID, hold buffer, bubble and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      imem.req   <= 1'b0;
      pc         <= resetPc;
      ifidPc     <= {addrWidth{1'b0}};
      ifidInstr  <= nopInstr;
      ifidValid  <= 1'b0;
      holdPc     <= {addrWidth{1'b0}};
      holdInstr  <= 32'h0000_0000;
      idexBubble <= 1'b0;
      stallCount <= {cntWidth{1'b0}};
    end else begin
      idexBubble <= ~selectMux | branchTaken;

      // A redirecting cycle is not counted even if the hazard unit stalls.
      if (stall && !branchTaken && (stallCount != {cntWidth{1'b1}})) begin
        stallCount <= stallCount + cntWidth'(1'b1);
      end

      // Redirect wins over stall in every state; leaving HOLD discards the buffer.
      if (branchTaken) begin
        pc        <= alignedTarget;
        ifidPc    <= {addrWidth{1'b0}};
        ifidInstr <= nopInstr;
        ifidValid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // imem.valid is deliberately not looked at: a late response from a
          // request cut short by reset must not be taken.
          state    <= REQ;
          imem.req <= 1'b1;
        end

        REQ: begin
          if (branchTaken) begin
            if (imem.valid) begin
              state    <= REQ;
              imem.req <= 1'b1;
            end else begin
              // Response still owed by memory; swallow it in DRAIN.
              state    <= DRAIN;
              imem.req <= 1'b0;
            end
          end else if (imem.valid) begin
            if (!stall) begin
              ifidPc    <= pc;
              ifidInstr <= imem.data;
              ifidValid <= 1'b1;
              pc        <= pcPlus4;
            end else begin
              holdPc    <= pc;
              holdInstr <= imem.data;
              state     <= HOLD;
              imem.req  <= 1'b0;
            end
          end else if (!stall) begin
            ifidPc    <= pc;
            ifidInstr <= nopInstr;
            ifidValid <= 1'b0;
          end
        end

        HOLD: begin
          if (branchTaken) begin
            state    <= REQ;
            imem.req <= 1'b1;
          end else if (!stall) begin
            ifidPc    <= holdPc;
            ifidInstr <= holdInstr;
            ifidValid <= 1'b1;
            pc        <= pcPlus4;
            state     <= REQ;
            imem.req  <= 1'b1;
          end
        end

        DRAIN: begin
          // The owed response ends DRAIN even when a new redirect lands in the
          // same cycle; otherwise the stage would wait for a strobe that never
          // comes.
          if (imem.valid) begin
            state    <= REQ;
            imem.req <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          imem.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stall_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stall_stage
// Directed scenarios followed by a randomized phase, every cycle compared
// against a behavioural model of the fetch stage kept in this bench.
// ---------------------------------------------------------------------------
module tb_fetch_stall_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        pcWrite, ifidWrite, selectMux, branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] pc, ifidPc, ifidInstr;
  logic        ifidValid, idexBubble;
  logic [15:0] stallCount;

  int errors = 0;
  int checks = 0;

  fetch_stall_stage_if #(.addrWidth(32)) imemBus ();

  fetch_stall_stage #(
    .addrWidth(32),
    .resetPc  (32'h0000_0000),
    .cntWidth (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pcWrite     (pcWrite),
    .ifidWrite   (ifidWrite),
    .selectMux   (selectMux),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .imem        (imemBus),
    .pc          (pc),
    .ifidPc      (ifidPc),
    .ifidInstr   (ifidInstr),
    .ifidValid   (ifidValid),
    .idexBubble  (idexBubble),
    .stallCount  (stallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // started: first request has gone out; fetching: request on the bus;
  // parked: an instruction waits in the hold buffer; owed: a discarded
  // response is still to come back from memory.
  logic [31:0] mPc, mIfPc, mIfInstr, mParkPc, mParkInstr;
  logic        mIfValid, mBubble, mStarted, mFetching, mParked, mOwed;
  int          mStalls;

  task automatic modelReset();
    mPc = 32'h0; mIfPc = 32'h0; mIfInstr = NOP; mIfValid = 1'b0;
    mBubble = 1'b0; mStarted = 1'b0; mFetching = 1'b0; mParked = 1'b0;
    mOwed = 1'b0; mStalls = 0; mParkPc = 32'h0; mParkInstr = 32'h0;
  endtask

  task automatic modelStep();
    logic stalled;
    logic gotResp;
    stalled = !pcWrite || !ifidWrite;
    gotResp = imemBus.valid;
    if (reset) begin
      modelReset();
    end else begin
      if (stalled && !branchTaken) mStalls = mStalls + 1;
      if (!mStarted) begin
        mStarted = 1'b1;
        mFetching = 1'b1;
        if (branchTaken) begin
          mPc = {branchTarget[31:2], 2'b00};
          mIfPc = 32'h0; mIfInstr = NOP; mIfValid = 1'b0;
        end
      end else if (branchTaken) begin
        if (mFetching) begin
          mFetching = gotResp;
          mOwed = !gotResp;
        end else if (mParked) begin
          mParked = 1'b0;
          mFetching = 1'b1;
        end else if (mOwed && gotResp) begin
          mOwed = 1'b0;
          mFetching = 1'b1;
        end
        mPc = {branchTarget[31:2], 2'b00};
        mIfPc = 32'h0; mIfInstr = NOP; mIfValid = 1'b0;
      end else if (mFetching) begin
        if (gotResp && !stalled) begin
          mIfPc = mPc; mIfInstr = imemBus.data; mIfValid = 1'b1;
          mPc = mPc + 32'd4;
        end else if (gotResp) begin
          mParkPc = mPc; mParkInstr = imemBus.data;
          mParked = 1'b1; mFetching = 1'b0;
        end else if (!stalled) begin
          mIfPc = mPc; mIfInstr = NOP; mIfValid = 1'b0;
        end
      end else if (mParked) begin
        if (!stalled) begin
          mIfPc = mParkPc; mIfInstr = mParkInstr; mIfValid = 1'b1;
          mPc = mPc + 32'd4;
          mParked = 1'b0; mFetching = 1'b1;
        end
      end else if (mOwed && gotResp) begin
        mOwed = 1'b0;
        mFetching = 1'b1;
      end
      mBubble = !selectMux || branchTaken;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] expCnt;
    expCnt = (mStalls > 65535) ? 32'h0000_FFFF : 32'(mStalls);
    chk({tag, ".pc"},         pc,                       mPc);
    chk({tag, ".imemAddr"},   imemBus.addr,             mPc);
    chk({tag, ".imemReq"},    32'(imemBus.req),         32'(mFetching));
    chk({tag, ".ifidPc"},     ifidPc,                   mIfPc);
    chk({tag, ".ifidInstr"},  ifidInstr,                mIfInstr);
    chk({tag, ".ifidValid"},  32'(ifidValid),           32'(mIfValid));
    chk({tag, ".idexBubble"}, 32'(idexBubble),          32'(mBubble));
    chk({tag, ".stallCount"}, 32'(stallCount),          expCnt);
  endtask

  task automatic cyc(input logic pw, input logic iw, input logic sm, input logic br,
                     input logic [31:0] tgt, input logic v, input logic [31:0] d,
                     input string tag);
    pcWrite = pw; ifidWrite = iw; selectMux = sm; branchTaken = br;
    branchTarget = tgt; imemBus.valid = v; imemBus.data = d;
    @(posedge clk);
    modelStep();
    #1;
    checkAll(tag);
  endtask

  // ---------------- stimulus ----------------
  logic        memOwes;
  int          memWait;
  logic        rv;
  logic [31:0] rd;

  initial begin
    reset = 1'b1; pcWrite = 1'b1; ifidWrite = 1'b1; selectMux = 1'b1;
    branchTaken = 1'b0; branchTarget = 32'h0;
    imemBus.valid = 1'b0; imemBus.data = 32'h0;
    modelReset();
    #1;
    checkAll("reset");
    chk("reset.nop", ifidInstr, 32'h0000_0013);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "reset_hold");

    // Release reset; a strobe during IDLE must be ignored.
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, "idle_ignore");
    chk("t1.addr0", imemBus.addr, 32'h0);
    chk("t1.req0", 32'(imemBus.req), 32'd1);

    // 1: one-cycle memory, no stalls
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0001, "t1.f0");
    chk("t1.addr4", imemBus.addr, 32'h4);
    chk("t1.ifidPc0", ifidPc, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0002, "t1.f4");
    chk("t1.addr8", imemBus.addr, 32'h8);
    chk("t1.ifidPc4", ifidPc, 32'h4);
    chk("t1.valid", 32'(ifidValid), 32'd1);

    // 2: load-use stall while the instruction at 0x8 returns
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00A0_0093, "t2.stall");
    chk("t2.ifidHeld", ifidPc, 32'h4);
    chk("t2.bubble", 32'(idexBubble), 32'd1);
    chk("t2.reqLow", 32'(imemBus.req), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "t2.release");
    chk("t2.instr", ifidInstr, 32'h00A0_0093);
    chk("t2.ifidPc", ifidPc, 32'h8);
    chk("t2.pc", pc, 32'hC);
    chk("t2.count", 32'(stallCount), 32'd1);

    // 3: three-cycle memory latency
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "t3.wait");
      chk("t3.addr", imemBus.addr, 32'hC);
      chk("t3.nop", 32'(ifidValid), 32'd0);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0020_8113, "t3.load");
    chk("t3.ifidPc", ifidPc, 32'hC);
    chk("t3.instr", ifidInstr, 32'h0020_8113);

    // 4: redirect while a request is pending
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "t4.pend");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0, "t4.branch");
    chk("t4.drainReq", 32'(imemBus.req), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "t4.drain");
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111, "t4.late");
    chk("t4.addr40", imemBus.addr, 32'h40);
    chk("t4.discard", ifidInstr, NOP);
    chk("t4.invalid", 32'(ifidValid), 32'd0);

    // 5: redirect + stall + response in one cycle (target low bits ignored)
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222, "t5.fetch");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h43, 1'b1, 32'h3333_3333, "t5.combo");
    chk("t5.pc", pc, 32'h40);
    chk("t5.count", 32'(stallCount), 32'd1);

    // Randomized phase with a single-outstanding memory of random latency
    memOwes = 1'b0;
    memWait = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!memOwes && mFetching) begin
        memOwes = 1'b1;
        memWait = $urandom_range(0, 3);
      end
      rd = $urandom;
      if (memOwes && memWait == 0) begin
        rv = 1'b1;
        memOwes = 1'b0;
      end else begin
        rv = 1'b0;
        if (memOwes) memWait = memWait - 1;
      end
      cyc(($urandom_range(0, 9) > 2), ($urandom_range(0, 9) > 2),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
          $urandom, rv, rd, "rnd");
    end

    // 6: long stall saturates the counter, then reset mid-request
    for (int i = 0; i < 70000; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "t6.stall");
    end
    chk("t6.sat", 32'(stallCount), 32'h0000_FFFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4444_4444, "t6.resume");
    chk("t6.req", 32'(imemBus.req), 32'd1);
    #3;
    reset = 1'b1;
    modelReset();
    #1;
    checkAll("t6.rst");
    chk("t6.rstPc", pc, 32'h0);
    chk("t6.rstInstr", ifidInstr, NOP);
    chk("t6.rstCount", 32'(stallCount), 32'd0);
    chk("t6.rstReq", 32'(imemBus.req), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555, "t6.rstHold");
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666, "t6.idle");
    chk("t6.noTake", 32'(ifidValid), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h7777_7777, "t6.first");
    chk("t6.firstInstr", ifidInstr, 32'h7777_7777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
